// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and the ALU it borrows.
//   - ALU op-code list (5-bit, shared with the ALU decoder)
//   - Sequencer state encoding
//   - Iteration count (equal to the data width)
package alu_muldiv_seq_pkg;

    localparam int DATA_W = 16;
    localparam int NITER  = 16;

    // ALU op codes. SUB computes alu_B - alu_A; its carry-out means "no borrow".
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLL = 5'd5;
    localparam logic [4:0] OP_SRL = 5'd6;
    localparam logic [4:0] OP_SRA = 5'd7;

    // Sequencer operation select
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer.
// Shift-add multiply and restoring divide, one iteration per granted ALU cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, a, b     request pulse (IDLE only), 0=MUL/1=DIV, operands
//   busy, done, dbz     status; done is a one-cycle pulse, dbz valid with done
//   res_hi, res_lo      MUL: product hi/lo; DIV: remainder/quotient
//   alu_req, alu_gnt    ALU borrow handshake; iteration advances on req & gnt
//   alu_A, alu_B, alu_Op, alu_sign   operands/op driven to the shared ALU
//   alu_Out, alu_OFL    ALU result and carry-out (same cycle)
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] res_hi,
    output logic [15:0] res_lo,
    output logic        dbz,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [4:0]  alu_Op,
    output logic        alu_sign,
    input  logic [15:0] alu_Out,
    input  logic        alu_OFL
);

    md_state_e   state_q, state_d;
    logic        op_q, op_d;
    logic [15:0] opnd_q, opnd_d;      // multiplicand or divisor
    logic [15:0] hi_q, hi_d;          // acc_hi or remainder
    logic [15:0] lo_q, lo_d;          // multiplier bits or quotient
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] res_hi_q, res_hi_d;
    logic [15:0] res_lo_q, res_lo_d;
    logic        dbz_q, dbz_d;

    // Per-iteration intermediates
    logic [16:0] sum17;
    logic [15:0] sh;
    logic        take;
    logic [15:0] hi_nx, lo_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        busy     = 1'b0;
        done     = 1'b0;
        alu_req  = 1'b0;
        alu_A    = '0;
        alu_B    = '0;
        alu_Op   = OP_ADD;
        sum17    = '0;
        sh       = '0;
        take     = 1'b0;
        hi_nx    = hi_q;
        lo_nx    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Both ops load a into the low register and b into the operand register
                    op_d   = op;
                    opnd_d = b;
                    hi_d   = '0;
                    lo_d   = a;
                    cnt_d  = '0;
                    dbz_d  = 1'b0;
                    if (op == MD_DIV && b == 16'h0000) begin
                        // Divide by zero short-circuits straight to DONE
                        state_d  = ST_DONE;
                        dbz_d    = 1'b1;
                        res_lo_d = 16'hFFFF;
                        res_hi_d = a;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                busy    = 1'b1;
                alu_req = 1'b1;
                alu_A   = opnd_q;
                if (op_q == MD_DIV) begin
                    // Restoring step: shift next dividend bit in, trial-subtract.
                    // A set msb means the 17-bit partial remainder exceeds any divisor.
                    sh     = {hi_q[14:0], lo_q[15]};
                    alu_B  = sh;
                    alu_Op = OP_SUB;
                    take   = hi_q[15] | alu_OFL;
                    hi_nx  = take ? alu_Out : sh;
                    lo_nx  = {lo_q[14:0], take};
                end else begin
                    // Shift-add step: conditionally add, then shift the 33-bit acc right
                    alu_B  = hi_q;
                    alu_Op = OP_ADD;
                    sum17  = lo_q[0] ? {alu_OFL, alu_Out} : {1'b0, hi_q};
                    hi_nx  = sum17[16:1];
                    lo_nx  = {sum17[0], lo_q[15:1]};
                end

                if (alu_gnt) begin
                    hi_d  = hi_nx;
                    lo_d  = lo_nx;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(NITER - 1)) begin
                        state_d  = ST_DONE;
                        res_hi_d = hi_nx;
                        res_lo_d = lo_nx;
                    end
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign res_hi   = res_hi_q;
    assign res_lo   = res_lo_q;
    assign dbz      = dbz_q;
    assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq with a behavioural ALU
// and an arithmetic reference model (a*b, a/b, a%b).
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a, b;
    logic        busy, done, dbz;
    logic [15:0] res_hi, res_lo;
    logic        alu_req, alu_gnt;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic [4:0]  alu_Op;
    logic        alu_sign, alu_OFL;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .dbz(dbz),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_A(alu_A), .alu_B(alu_B),
        .alu_Op(alu_Op), .alu_sign(alu_sign), .alu_Out(alu_Out), .alu_OFL(alu_OFL)
    );

    // Shared ALU: ADD gives carry-out, SUB computes B - A with OFL = no borrow
    logic [16:0] alu_wide;
    always_comb begin
        if (alu_Op == OP_SUB)
            alu_wide = {1'b0, alu_B} - {1'b0, alu_A};
        else
            alu_wide = {1'b0, alu_B} + {1'b0, alu_A};
        alu_Out = alu_wide[15:0];
        alu_OFL = (alu_Op == OP_SUB) ? ~alu_wide[16] : alu_wide[16];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation end to end. mode: 0 = grant always, 1 = grant on odd cycles,
    // 2 = random grant. poke pulses a competing start while busy.
    task automatic run_op(input logic o, input logic [15:0] ai, input logic [15:0] bi,
                          input int mode, input bit poke);
        logic [31:0] prod;
        logic [15:0] eh, el;
        logic        ed, g;
        int          grants, exp_c, got_c;
        bit          run_ok;

        if (o == MD_MUL) begin
            prod = {16'h0, ai} * {16'h0, bi};
            eh = prod[31:16]; el = prod[15:0]; ed = 1'b0;
        end else if (bi == 16'h0) begin
            eh = ai; el = 16'hFFFF; ed = 1'b1;
        end else begin
            el = ai / bi; eh = ai % bi; ed = 1'b0;
        end
        exp_c  = ed ? 1 : -1;
        got_c  = -1;
        grants = 0;
        run_ok = 1'b1;

        @(negedge clk);
        check_eq("idle_busy", {31'h0, busy}, 32'h0);
        start = 1'b1; op = o; a = ai; b = bi; alu_gnt = 1'b0;

        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got_c = c;
                break;
            end
            if (alu_req !== 1'b1 || busy !== 1'b1) run_ok = 1'b0;
            if (poke && c == 3) begin
                start = 1'b1; op = ~o; a = ~ai; b = bi ^ 16'h0005;
            end
            case (mode)
                0:       g = 1'b1;
                1:       g = c[0];
                default: g = 1'($urandom_range(0, 1));
            endcase
            alu_gnt = g;
            if (g) begin
                grants++;
                if (grants == NITER) exp_c = c + 1;
            end
        end

        check_eq("done_cycle", 32'(got_c), 32'(exp_c));
        check_eq("res_hi", {16'h0, res_hi}, {16'h0, eh});
        check_eq("res_lo", {16'h0, res_lo}, {16'h0, el});
        check_eq("dbz", {31'h0, dbz}, {31'h0, ed});
        check_eq("busy_done", {31'h0, busy}, 32'h1);
        check_eq("req_in_done", {31'h0, alu_req}, 32'h0);
        check_eq("run_signals", {31'h0, run_ok}, 32'h1);

        alu_gnt = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", {31'h0, done}, 32'h0);
        check_eq("busy_after", {31'h0, busy}, 32'h0);
        check_eq("alu_idle", {11'h0, alu_req, alu_Op, alu_A | alu_B}, 32'h0);
        check_eq("hold", {res_hi, res_lo}, {eh, el});
        check_eq("dbz_hold", {31'h0, dbz}, {31'h0, ed});
        $display("txn %s a=%h b=%h mode=%0d -> hi=%h lo=%h dbz=%0d cycles=%0d",
                 (o == MD_MUL) ? "MUL" : "DIV", ai, bi, mode, res_hi, res_lo, dbz, got_c);
    endtask

    initial begin
        bit saw_done;
        logic        ro;
        logic [15:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; alu_gnt = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_status", {28'h0, busy, done, dbz, alu_req}, 32'h0);
        check_eq("rst_res", {res_hi, res_lo}, 32'h0);
        check_eq("rst_alu", {11'h0, alu_sign, alu_Op, alu_A | alu_B}, 32'h0);
        rst = 1'b0;

        // Directed cases
        run_op(MD_MUL, 16'h1234, 16'h0010, 0, 1'b0);
        run_op(MD_MUL, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(MD_DIV, 16'd100,  16'd7,    0, 1'b0);
        run_op(MD_DIV, 16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(MD_DIV, 16'h00AB, 16'h0000, 0, 1'b0);
        run_op(MD_MUL, 16'h0003, 16'h0005, 1, 1'b1);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; op = MD_DIV; a = 16'd1000; b = 16'd3; alu_gnt = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 8) rst = 1'b1;
        end
        @(negedge clk);
        check_eq("mid_rst_status", {28'h0, busy, done, dbz, alu_req}, 32'h0);
        check_eq("mid_rst_res", {res_hi, res_lo}, 32'h0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_eq("no_done_after_rst", {31'h0, saw_done}, 32'h0);
        $display("txn RESET mid-DIV -> busy=%0d res=%h%h", busy, res_hi, res_lo);
        run_op(MD_DIV, 16'd1000, 16'd3, 0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            run_op(ro, ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
